// File: rtl/snake_body.sv
// Snake movement and collision engine on a 32x24 cell grid.
// Advances the snake one cell per game tick, detects wall/self collisions,
// pulses get_food when the head lands on the food cell, and answers
// per-cell occupancy queries for the renderer.
// Optional build macro: WRAP_EN -- edges wrap around instead of colliding.
module snake_body #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_state,
  input  logic       step,
  input  logic [1:0] dir_in,
  input  logic [4:0] food_x,
  input  logic [4:0] food_y,
  output logic       get_food,
  output logic       hit,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] snake_len,
  input  logic [4:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_body,
  output logic       query_head
);

  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] D_UP    = 2'b00;
  localparam logic [1:0] D_DOWN  = 2'b01;
  localparam logic [1:0] D_LEFT  = 2'b10;
  localparam logic [1:0] D_RIGHT = 2'b11;
  localparam logic [4:0] X_MAX   = 5'd31;
  localparam logic [4:0] Y_MAX   = 5'd23;

`ifdef WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {S_INIT, S_RUN, S_DEAD} state_t;

  state_t     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [1:0] dir_q, dir_d;
  logic       get_food_q, get_food_d;
  logic       hit_q, hit_d;
  logic       play_q;
  logic [4:0] seg_x_q [MAX_LEN];
  logic [4:0] seg_y_q [MAX_LEN];
  logic [4:0] seg_x_d [MAX_LEN];
  logic [4:0] seg_y_d [MAX_LEN];

  logic       playing;
  logic       init_evt;
  logic [1:0] new_dir;
  logic [4:0] nxt_x, nxt_y;
  logic       wall;
  logic       eat;
  logic [5:0] self_lim;
  logic       self_hit;

  assign playing  = (game_state == GS_PLAY);
  // A fresh game starts on reset or on entry into the play state.
  assign init_evt = rst | (playing & ~play_q);
  // Reversal requests (up<->down, left<->right differ only in bit 0) are ignored.
  assign new_dir  = (dir_in == {dir_q[1], ~dir_q[0]}) ? dir_q : dir_in;
  assign eat      = (nxt_x == food_x) && (nxt_y == food_y);

  // Candidate head cell; edge crossings flag a wall hit unless wrapping is built in.
  always_comb begin
    nxt_x = seg_x_q[0];
    nxt_y = seg_y_q[0];
    wall  = 1'b0;
    case (new_dir)
      D_UP: begin
        if (seg_y_q[0] == 5'd0) begin
          wall  = !WRAP;
          nxt_y = Y_MAX;
        end else begin
          nxt_y = seg_y_q[0] - 5'd1;
        end
      end
      D_DOWN: begin
        if (seg_y_q[0] == Y_MAX) begin
          wall  = !WRAP;
          nxt_y = 5'd0;
        end else begin
          nxt_y = seg_y_q[0] + 5'd1;
        end
      end
      D_LEFT: begin
        if (seg_x_q[0] == 5'd0) begin
          wall  = !WRAP;
          nxt_x = X_MAX;
        end else begin
          nxt_x = seg_x_q[0] - 5'd1;
        end
      end
      default: begin
        if (seg_x_q[0] == X_MAX) begin
          wall  = !WRAP;
          nxt_x = 5'd0;
        end else begin
          nxt_x = seg_x_q[0] + 5'd1;
        end
      end
    endcase
  end

  // Self collision: the tail cell vacates on a plain move but stays when eating.
  always_comb begin
    self_lim = eat ? {1'b0, len_q} : ({1'b0, len_q} - 6'd1);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < self_lim) && (seg_x_q[i] == nxt_x) && (seg_y_q[i] == nxt_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Next-state logic: init, move/eat, collision, and game-state driven transitions.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    dir_d      = dir_q;
    get_food_d = 1'b0;
    hit_d      = 1'b0;
    seg_x_d    = seg_x_q;
    seg_y_d    = seg_y_q;
    if (init_evt) begin
      state_d = S_INIT;
      len_d   = 5'(INIT_LEN);
      dir_d   = D_RIGHT;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = 5'(16 - i);
        seg_y_d[i] = 5'd12;
      end
    end else begin
      case (state_q)
        S_INIT: state_d = S_RUN;
        S_RUN: begin
          if (playing && step) begin
            if (wall || self_hit) begin
              hit_d   = 1'b1;
              state_d = S_DEAD;
            end else begin
              for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x_d[i] = seg_x_q[i-1];
                seg_y_d[i] = seg_y_q[i-1];
              end
              seg_x_d[0] = nxt_x;
              seg_y_d[0] = nxt_y;
              dir_d      = new_dir;
              if (eat) begin
                get_food_d = 1'b1;
                if (len_q < 5'(MAX_LEN)) len_d = len_q + 5'd1;
              end
            end
          end
        end
        S_DEAD: if (!playing) state_d = S_INIT;
        default: state_d = S_INIT;
      endcase
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      len_q      <= 5'(INIT_LEN);
      dir_q      <= D_RIGHT;
      get_food_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      dir_q      <= dir_d;
      get_food_q <= get_food_d;
      hit_q      <= hit_d;
    end
  end

  // Play-state history for entry detection; tracks the input even during reset.
  always_ff @(posedge clk) begin
    play_q <= playing;
  end

  // Segment storage; reset reaches it through init_evt.
  always_ff @(posedge clk) begin
    seg_x_q <= seg_x_d;
    seg_y_q <= seg_y_d;
  end

  // Renderer occupancy lookup over live segments only.
  always_comb begin
    query_body = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < len_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        query_body = 1'b1;
      end
    end
    if (query_y > Y_MAX) query_body = 1'b0;
  end

  assign query_head = (query_y <= Y_MAX) && (seg_x_q[0] == query_x) && (seg_y_q[0] == query_y);
  assign get_food   = get_food_q;
  assign hit        = hit_q;
  assign head_x     = seg_x_q[0];
  assign head_y     = seg_y_q[0];
  assign snake_len  = len_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed testbench for snake_body with hand-computed expectations.
// Honors WRAP_EN the same way as the design build.
module tb_snake_body;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] game_state;
  logic       step;
  logic [1:0] dir_in;
  logic [4:0] food_x, food_y;
  logic       get_food, hit;
  logic [4:0] head_x, head_y, snake_len;
  logic [4:0] query_x, query_y;
  logic       query_body, query_head;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  snake_body #(.MAX_LEN(16), .INIT_LEN(3)) dut (
    .clk(clk), .rst(rst), .game_state(game_state), .step(step), .dir_in(dir_in),
    .food_x(food_x), .food_y(food_y), .get_food(get_food), .hit(hit),
    .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
    .query_x(query_x), .query_y(query_y), .query_body(query_body), .query_head(query_head)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; game_state = 2'b01; step = 1'b0; dir_in = RIGHT;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic do_step(input logic [1:0] d);
    dir_in = d; step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic set_food(input int x, input int y);
    food_x = 5'(x); food_y = 5'(y);
  endtask

  task automatic q_body(input string tag, input int x, input int y, input int exp);
    query_x = 5'(x); query_y = 5'(y);
    #1;
    chk(tag, int'(query_body), exp);
  endtask

  initial begin
    rst = 1'b1; game_state = 2'b01; step = 1'b0; dir_in = RIGHT;
    food_x = 5'd0; food_y = 5'd0; query_x = 5'd0; query_y = 5'd0;

    // Reset state
    do_reset();
    chk("rst_head_x", head_x, 16);
    chk("rst_head_y", head_y, 12);
    chk("rst_len", snake_len, 3);
    chk("rst_hit", hit, 0);
    chk("rst_food", get_food, 0);
    q_body("rst_q14", 14, 12, 1);
    q_body("rst_q13", 13, 12, 0);
    query_x = 5'd16; query_y = 5'd12; #1;
    chk("rst_qhead", query_head, 1);

    // 1: plain move right
    set_food(0, 0);
    do_step(RIGHT);
    chk("t1_head_x", head_x, 17);
    chk("t1_head_y", head_y, 12);
    chk("t1_len", snake_len, 3);
    chk("t1_food", get_food, 0);
    q_body("t1_q15", 15, 12, 1);
    q_body("t1_q14", 14, 12, 0);

    // 2: eat from (17,12)
    set_food(18, 12);
    do_step(RIGHT);
    chk("t2_food", get_food, 1);
    chk("t2_len", snake_len, 4);
    chk("t2_head_x", head_x, 18);
    q_body("t2_q15", 15, 12, 1);
    q_body("t2_q14", 14, 12, 0);
    tick();
    chk("t2_food_pulse", get_food, 0);

    // 3: reversal ignored
    do_reset();
    set_food(0, 0);
    do_step(LEFT);
    chk("t3a_head_x", head_x, 17);
    do_step(LEFT);
    chk("t3_head_x", head_x, 18);
    chk("t3_head_y", head_y, 12);
    chk("t3_hit", hit, 0);

    // 4: run into the right edge
    do_reset();
    set_food(0, 0);
    for (int k = 0; k < 15; k++) do_step(RIGHT);
    chk("t4_head_x15", head_x, 31);
    chk("t4_hit15", hit, 0);
    do_step(RIGHT);
`ifdef WRAP_EN
    chk("t4w_hit", hit, 0);
    chk("t4w_head_x", head_x, 0);
    chk("t4w_head_y", head_y, 12);
    query_x = 5'd0; query_y = 5'd12; #1;
    chk("t4w_qhead", query_head, 1);
`else
    chk("t4_hit", hit, 1);
    chk("t4_head_x", head_x, 31);
    chk("t4_len", snake_len, 3);
    tick();
    chk("t4_hit_pulse", hit, 0);
    do_step(RIGHT);
    chk("t4_dead_hit", hit, 0);
    chk("t4_dead_head_x", head_x, 31);
    // Leave play, then re-enter: fresh snake
    game_state = 2'b10;
    do_step(UP);
    chk("t4_over_head_y", head_y, 12);
    game_state = 2'b01;
    tick();
    chk("t4_reinit_head_x", head_x, 16);
    chk("t4_reinit_len", snake_len, 3);
    tick();
    do_step(RIGHT);
    chk("t4_reinit_step", head_x, 17);
`endif

    // 5: grow to 5 and turn into own body
    do_reset();
    set_food(17, 12); do_step(RIGHT);
    set_food(18, 12); do_step(RIGHT);
    set_food(0, 0);
    do_step(RIGHT); do_step(RIGHT);
    chk("t5_head_x", head_x, 20);
    chk("t5_len", snake_len, 5);
    q_body("t5_q16", 16, 12, 1);
    q_body("t5_q15", 15, 12, 0);
    do_step(DOWN);
    chk("t5_down_y", head_y, 13);
    chk("t5_down_hit", hit, 0);
    do_step(LEFT);
    chk("t5_left_x", head_x, 19);
    chk("t5_left_hit", hit, 0);
    do_step(UP);
    chk("t5_up_hit", hit, 1);
    chk("t5_up_head_x", head_x, 19);
    chk("t5_up_head_y", head_y, 13);

    // Length saturation at MAX_LEN
    do_reset();
    for (int k = 17; k < 30; k++) begin
      set_food(k, 12);
      do_step(RIGHT);
    end
    chk("sat_len16", snake_len, 16);
    set_food(30, 12);
    do_step(RIGHT);
    chk("sat_food", get_food, 1);
    chk("sat_len", snake_len, 16);
    q_body("sat_q15", 15, 12, 1);
    q_body("sat_q14", 14, 12, 0);

    // 6: reset wins over a step that would eat
    do_reset();
    set_food(17, 12);
    rst = 1'b1; dir_in = RIGHT; step = 1'b1;
    tick();
    rst = 1'b0; step = 1'b0;
    chk("t6_food", get_food, 0);
    chk("t6_head_x", head_x, 16);
    chk("t6_len", snake_len, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
